// File: rtl/aq_axis_pattern_gen.sv
// AXI4-Stream pattern source: prefix+counter, walking one, Galois LFSR or constant frames,
// with programmable frame length/count, inter-beat gaps and a graceful stop.
module aq_axis_pattern_gen #(
    parameter int          DATA_WIDTH = 64,
    parameter int          LEN_WIDTH  = 16,
    parameter int          GAP_WIDTH  = 8,
    parameter logic [31:0] PREFIX     = 32'h0011_2233
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    START,
    input  logic                    STOP,
    input  logic [1:0]              MODE,
    input  logic [LEN_WIDTH-1:0]    FRAME_LEN,
    input  logic [15:0]             FRAME_COUNT,
    input  logic [GAP_WIDTH-1:0]    GAP,
    input  logic [31:0]             SEED,
    output logic [DATA_WIDTH-1:0]   W_AXIS_TDATA,
    output logic                    W_AXIS_TVALID,
    input  logic                    W_AXIS_TREADY,
    output logic [DATA_WIDTH/8-1:0] W_AXIS_TSTRB,
    output logic [DATA_WIDTH/8-1:0] W_AXIS_TKEEP,
    output logic                    W_AXIS_TLAST,
    output logic                    BUSY,
    output logic                    DONE,
    output logic [15:0]             FRAMES_SENT
);

    localparam int NL = DATA_WIDTH / 32;
    localparam int PW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    state_t                 state, state_next;
    logic [1:0]             mode_q;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [15:0]            count_q;
    logic [GAP_WIDTH-1:0]   gap_q;
    logic [31:0]            seed_q;
    logic [31:0]            seq;
    logic [31:0]            lfsr;
    logic [PW-1:0]          walk;
    logic [LEN_WIDTH-1:0]   beat;
    logic [15:0]            frame_cnt;
    logic [GAP_WIDTH-1:0]   gap_cnt;
    logic                   stop_pend;
    logic [DATA_WIDTH-1:0]  tdata;
    logic [15:0]            frames_sent;
    logic                   done;

    logic                   accept, is_last, start_ok, final_frame, stop_now, end_run;
    logic [15:0]            frame_cnt_inc;
    logic [31:0]            seq_next, lfsr_next, seed_init;
    logic [PW-1:0]          walk_next;

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [1:0]    m,
                                                      input logic [31:0]   s,
                                                      input logic [31:0]   l,
                                                      input logic [31:0]   sd,
                                                      input logic [PW-1:0] w);
        logic [DATA_WIDTH-1:0] d;
        d = '0;
        case (m)
            2'd0: begin
                for (int i = 0; i < NL; i++) d[32*i +: 32] = PREFIX;
                d[31:0] = s;
            end
            2'd1: d[w] = 1'b1;
            2'd2: for (int i = 0; i < NL; i++) d[32*i +: 32] = l;
            default: for (int i = 0; i < NL; i++) d[32*i +: 32] = sd;
        endcase
        return d;
    endfunction

    assign accept        = (state == S_SEND) && W_AXIS_TREADY;
    assign is_last       = (beat == len_q - LEN_WIDTH'(1));
    assign start_ok      = (state == S_IDLE) && START && (FRAME_LEN != '0);
    assign frame_cnt_inc = frame_cnt + 16'd1;
    assign final_frame   = (count_q != 16'd0) && (frame_cnt_inc == count_q);
    assign stop_now      = stop_pend || STOP;
    assign end_run       = accept && is_last && (final_frame || stop_now);
    assign seq_next      = seq + 32'd1;
    // Right-shift Galois form of x^32+x^22+x^2+x+1.
    assign lfsr_next     = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
    assign seed_init     = (SEED == 32'd0) ? 32'd1 : SEED;
    // Walking-one position tracks seq mod DATA_WIDTH, including across a seq wrap.
    assign walk_next     = ((walk == PW'(DATA_WIDTH - 1)) || (seq == 32'hFFFF_FFFF)) ? '0 : walk + PW'(1);

    always_ff @(posedge ACLK) begin
        if (ARESET) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start_ok) state_next = S_SEND;
            S_SEND: begin
                if (accept) begin
                    if (end_run)            state_next = S_IDLE;
                    else if (gap_q != '0)   state_next = S_GAP;
                    else                    state_next = S_SEND;
                end
            end
            S_GAP: begin
                // beat == 0 here means the beat before this gap closed a frame.
                if (stop_now && (beat == '0))      state_next = S_IDLE;
                else if (gap_cnt == GAP_WIDTH'(1)) state_next = S_SEND;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        W_AXIS_TVALID = (state == S_SEND);
        W_AXIS_TLAST  = (state == S_SEND) && is_last;
        BUSY          = (state != S_IDLE);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            mode_q      <= '0;
            len_q       <= '0;
            count_q     <= '0;
            gap_q       <= '0;
            seed_q      <= '0;
            seq         <= '0;
            lfsr        <= 32'd1;
            walk        <= '0;
            beat        <= '0;
            frame_cnt   <= '0;
            gap_cnt     <= '0;
            stop_pend   <= 1'b0;
            tdata       <= '0;
            frames_sent <= '0;
            done        <= 1'b0;
        end else begin
            done <= (state != S_IDLE) && (state_next == S_IDLE);

            if (state_next == S_IDLE)        stop_pend <= 1'b0;
            else if (STOP && state != S_IDLE) stop_pend <= 1'b1;

            if (start_ok) begin
                mode_q      <= MODE;
                len_q       <= FRAME_LEN;
                count_q     <= FRAME_COUNT;
                gap_q       <= GAP;
                seed_q      <= SEED;
                seq         <= '0;
                lfsr        <= seed_init;
                walk        <= '0;
                beat        <= '0;
                frame_cnt   <= '0;
                frames_sent <= '0;
                tdata       <= pattern(MODE, 32'd0, seed_init, SEED, '0);
            end

            if (accept) begin
                seq     <= seq_next;
                lfsr    <= lfsr_next;
                walk    <= walk_next;
                gap_cnt <= gap_q;
                tdata   <= pattern(mode_q, seq_next, lfsr_next, seed_q, walk_next);
                if (is_last) begin
                    beat        <= '0;
                    frame_cnt   <= frame_cnt_inc;
                    frames_sent <= frames_sent + 16'd1;
                end else begin
                    beat <= beat + LEN_WIDTH'(1);
                end
            end

            if (state == S_GAP) gap_cnt <= gap_cnt - GAP_WIDTH'(1);
        end
    end

    assign W_AXIS_TDATA = tdata;
    assign W_AXIS_TSTRB = '1;
    assign W_AXIS_TKEEP = '1;
    assign DONE         = done;
    assign FRAMES_SENT  = frames_sent;

endmodule

// File: tb/tb_aq_axis_pattern_gen.sv
// Directed bench for aq_axis_pattern_gen: each pattern mode, frame/gap/stop sequencing,
// ignored starts and mid-frame reset, checked against hand-computed values.
module tb_aq_axis_pattern_gen;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        START, STOP;
    logic [1:0]  MODE;
    logic [15:0] FRAME_LEN, FRAME_COUNT;
    logic [7:0]  GAP;
    logic [31:0] SEED;
    logic [63:0] W_AXIS_TDATA;
    logic        W_AXIS_TVALID, W_AXIS_TREADY, W_AXIS_TLAST;
    logic [7:0]  W_AXIS_TSTRB, W_AXIS_TKEEP;
    logic        BUSY, DONE;
    logic [15:0] FRAMES_SENT;

    localparam logic [63:0] PFX = 64'h0011_2233_0000_0000;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] beat_dat[$];
    bit          beat_last[$];
    int          beat_cyc[$];
    int          done_cyc;
    logic [31:0] lfsr_tab [12] = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002, 32'h6018_0001,
                                   32'hB02C_0003, 32'hD836_0002, 32'h6C1B_0001, 32'hB62D_8003,
                                   32'hDB36_C002, 32'h6D9B_6001, 32'hB6ED_B003, 32'hDB56_D802};

    aq_axis_pattern_gen #(.DATA_WIDTH(64), .LEN_WIDTH(16), .GAP_WIDTH(8), .PREFIX(32'h0011_2233)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .START(START), .STOP(STOP), .MODE(MODE),
        .FRAME_LEN(FRAME_LEN), .FRAME_COUNT(FRAME_COUNT), .GAP(GAP), .SEED(SEED),
        .W_AXIS_TDATA(W_AXIS_TDATA), .W_AXIS_TVALID(W_AXIS_TVALID), .W_AXIS_TREADY(W_AXIS_TREADY),
        .W_AXIS_TSTRB(W_AXIS_TSTRB), .W_AXIS_TKEEP(W_AXIS_TKEEP), .W_AXIS_TLAST(W_AXIS_TLAST),
        .BUSY(BUSY), .DONE(DONE), .FRAMES_SENT(FRAMES_SENT)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Pulses START with the given config, then scrambles config to prove it was latched.
    task automatic start_gen(input logic [1:0] m, input int len, input int cnt, input int gap,
                             input logic [31:0] seed);
        MODE = m; FRAME_LEN = 16'(len); FRAME_COUNT = 16'(cnt); GAP = 8'(gap); SEED = seed;
        START = 1'b1;
        @(negedge ACLK);
        START = 1'b0;
        MODE = ~m; FRAME_LEN = 16'd3; FRAME_COUNT = 16'd5; GAP = 8'd0; SEED = ~seed;
    endtask

    // Accepts beats until DONE; optional random TREADY and a STOP on beat index stop_at.
    task automatic run(input int budget, input bit rnd, input int stop_at);
        bit          held = 1'b0;
        logic [63:0] hdat = '0;
        beat_dat.delete(); beat_last.delete(); beat_cyc.delete();
        done_cyc = -1;
        for (int cyc = 0; cyc < budget; cyc++) begin
            STOP = 1'b0;
            if (DONE) begin
                done_cyc = cyc;
                break;
            end
            if (held) begin
                check_val("valid_held", W_AXIS_TVALID, 1);
                check_val("data_held", W_AXIS_TDATA, hdat);
            end
            if (W_AXIS_TVALID) begin
                W_AXIS_TREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (W_AXIS_TREADY) begin
                    beat_dat.push_back(W_AXIS_TDATA);
                    beat_last.push_back(W_AXIS_TLAST);
                    beat_cyc.push_back(cyc);
                    if (beat_dat.size() - 1 == stop_at) STOP = 1'b1;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hdat = W_AXIS_TDATA;
                end
            end else begin
                W_AXIS_TREADY = 1'b0;
                held = 1'b0;
            end
            @(negedge ACLK);
        end
        W_AXIS_TREADY = 1'b0;
        STOP = 1'b0;
        check_val("done_seen", done_cyc >= 0, 1);
        if (done_cyc >= 0) begin
            check_val("busy_at_done", BUSY, 0);
            @(negedge ACLK);
            check_val("done_one_cycle", DONE, 0);
        end
    endtask

    initial begin
        int n;
        bit saw_done;
        ARESET = 1'b1; START = 1'b0; STOP = 1'b0; MODE = '0; FRAME_LEN = '0;
        FRAME_COUNT = '0; GAP = '0; SEED = '0; W_AXIS_TREADY = 1'b0;
        repeat (3) @(negedge ACLK);
        check_val("rst_tvalid", W_AXIS_TVALID, 0);
        check_val("rst_tlast", W_AXIS_TLAST, 0);
        check_val("rst_tdata", W_AXIS_TDATA, 0);
        check_val("rst_busy", BUSY, 0);
        check_val("rst_done", DONE, 0);
        check_val("rst_frames", FRAMES_SENT, 0);
        check_val("rst_strb", W_AXIS_TSTRB, 8'hFF);
        check_val("rst_keep", W_AXIS_TKEEP, 8'hFF);
        ARESET = 1'b0;
        @(negedge ACLK);

        // Mode 0, one 512-beat frame, back to back.
        start_gen(2'd0, 512, 1, 0, 32'd0);
        check_val("m0_first_valid", W_AXIS_TVALID, 1);
        run(2000, 1'b0, -1);
        check_val("m0_beats", beat_dat.size(), 512);
        for (int i = 0; i < beat_dat.size(); i++) begin
            check_val($sformatf("m0_data_%0d", i), beat_dat[i], PFX | 64'(i));
            check_val($sformatf("m0_last_%0d", i), beat_last[i], i == 511);
        end
        if (beat_cyc.size() == 512) begin
            check_val("m0_rate", beat_cyc[511] - beat_cyc[0], 511);
            check_val("m0_done_lat", done_cyc - beat_cyc[511], 1);
        end
        check_val("m0_frames", FRAMES_SENT, 1);

        // Mode 2, seed 0 -> LFSR starts at 1; gaps of 2, random ready.
        start_gen(2'd2, 4, 3, 2, 32'd0);
        run(2000, 1'b1, -1);
        check_val("m2_beats", beat_dat.size(), 12);
        for (int i = 0; i < beat_dat.size() && i < 12; i++) begin
            check_val($sformatf("m2_data_%0d", i), beat_dat[i], {lfsr_tab[i], lfsr_tab[i]});
            check_val($sformatf("m2_last_%0d", i), beat_last[i], (i % 4) == 3);
            if (i > 0) check_val($sformatf("m2_gap_%0d", i), beat_cyc[i] - beat_cyc[i-1] >= 3, 1);
        end
        check_val("m2_frames", FRAMES_SENT, 3);

        // Mode 1, 70 beats: bit 0..63 then 0..5.
        start_gen(2'd1, 70, 1, 0, 32'd0);
        run(1000, 1'b0, -1);
        check_val("m1_beats", beat_dat.size(), 70);
        for (int i = 0; i < beat_dat.size(); i++)
            check_val($sformatf("m1_data_%0d", i), beat_dat[i], 64'd1 << (i % 64));

        // Free-running with STOP on beat 3 of frame 2: frame 2 still completes.
        start_gen(2'd0, 8, 0, 0, 32'd0);
        run(1000, 1'b0, 10);
        check_val("stop_beats", beat_dat.size(), 16);
        for (int i = 0; i < beat_dat.size(); i++)
            check_val($sformatf("stop_data_%0d", i), beat_dat[i], PFX | 64'(i));
        if (beat_last.size() == 16) check_val("stop_last", beat_last[15], 1);
        check_val("stop_frames", FRAMES_SENT, 2);
        STOP = 1'b1;
        @(negedge ACLK);
        STOP = 1'b0;
        check_val("stop_idle_ignored", BUSY, 0);
        start_gen(2'd0, 2, 1, 0, 32'd0);
        check_val("restart_frames", FRAMES_SENT, 0);
        check_val("restart_data", W_AXIS_TDATA, PFX);
        run(100, 1'b0, -1);
        check_val("restart_beats", beat_dat.size(), 2);
        check_val("restart_frames_end", FRAMES_SENT, 1);

        // START with FRAME_LEN=0 is ignored.
        start_gen(2'd0, 0, 1, 0, 32'd0);
        check_val("len0_busy", BUSY, 0);
        check_val("len0_valid", W_AXIS_TVALID, 0);
        check_val("len0_frames", FRAMES_SENT, 1);

        // START while busy is ignored; mode 3 constant with gap 3.
        start_gen(2'd3, 4, 1, 3, 32'hA5A5_5A5A);
        check_val("m3_first", W_AXIS_TDATA, 64'hA5A5_5A5A_A5A5_5A5A);
        check_val("m3_frames_clr", FRAMES_SENT, 0);
        start_gen(2'd0, 1, 1, 0, 32'd0);
        check_val("busy_start_valid", W_AXIS_TVALID, 1);
        check_val("busy_start_data", W_AXIS_TDATA, 64'hA5A5_5A5A_A5A5_5A5A);
        run(200, 1'b0, -1);
        check_val("m3_beats", beat_dat.size(), 4);
        for (int i = 0; i < beat_dat.size(); i++) begin
            check_val($sformatf("m3_data_%0d", i), beat_dat[i], 64'hA5A5_5A5A_A5A5_5A5A);
            check_val($sformatf("m3_last_%0d", i), beat_last[i], i == 3);
            if (i > 0) check_val($sformatf("m3_gap_%0d", i), beat_cyc[i] - beat_cyc[i-1], 4);
        end

        // Reset at beat 5 of frame 2: abandoned, no DONE.
        start_gen(2'd0, 8, 0, 0, 32'd0);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (W_AXIS_TVALID && n == 12) break;
            W_AXIS_TREADY = W_AXIS_TVALID;
            if (W_AXIS_TVALID) n++;
            @(negedge ACLK);
        end
        check_val("rst_mid_reached", n, 12);
        check_val("rst_mid_frames_before", FRAMES_SENT, 1);
        ARESET = 1'b1;
        W_AXIS_TREADY = 1'b1;
        @(negedge ACLK);
        check_val("rst_mid_valid", W_AXIS_TVALID, 0);
        check_val("rst_mid_busy", BUSY, 0);
        check_val("rst_mid_frames", FRAMES_SENT, 0);
        check_val("rst_mid_tlast", W_AXIS_TLAST, 0);
        ARESET = 1'b0;
        W_AXIS_TREADY = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (DONE || W_AXIS_TVALID) saw_done = 1'b1;
            @(negedge ACLK);
        end
        check_val("rst_mid_quiet", saw_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
